// File: rtl/mem_port_arbiter.sv
// Arbitrates the main-memory line port between I-cache refills and D-cache refills/write-backs.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, D over I.
module mem_port_arbiter #(
    parameter int LINE_AW     = 28,
    parameter int LINE_W      = 128,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reqI,
    input  logic [LINE_AW-1:0] addrI,
    output logic               respI_valid,
    output logic [LINE_W-1:0]  respI_data,
    input  logic               reqD,
    input  logic               weD,
    input  logic [LINE_AW-1:0] addrD,
    input  logic [LINE_W-1:0]  wdataD,
    output logic               respD_valid,
    output logic [LINE_W-1:0]  respD_data,
    output logic               ackD,
    output logic               mem_req,
    output logic               mem_we,
    output logic [LINE_AW-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic [LINE_W-1:0]  mem_rdata,
    input  logic               mem_ready,
    input  logic               mem_ack,
    output logic               timeout_err
);

    // state   | meaning
    // IDLE    | no owner; requests are sampled and one is granted
    // BUSY    | request held on the memory port, waiting for response or watchdog
    // RELEASE | one dead cycle so the finished requester can drop its level request
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_grant;
    logic               w_pick_d;
    logic               w_cap_rd;
    logic               w_cap_wr;
    logic               w_abort;

    logic               r_owner_d;
    logic               r_we;
    logic [LINE_AW-1:0] r_addr;
    logic [LINE_W-1:0]  r_wdata;
    logic [TW-1:0]      r_timer;
    logic               r_respI_valid;
    logic               r_respD_valid;
    logic               r_ackD;
    logic               r_timeout_err;
    logic [LINE_W-1:0]  r_respI_data;
    logic [LINE_W-1:0]  r_respD_data;

`ifdef MEM_ARB_RR_EN
    logic               r_last_d;

    // On a tie the requester that did not win last time gets the port.
    assign w_pick_d = reqD & (~reqI | ~r_last_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b1;
        end else if (w_grant) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = reqD;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_cap_rd    = 1'b0;
        w_cap_wr    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reqI | reqD) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                // A response of the wrong type never completes the transaction.
                if (!r_we && mem_ready) begin
                    w_cap_rd    = 1'b1;
                    w_state_nxt = S_RELEASE;
                end else if (r_we && mem_ack) begin
                    w_cap_wr    = 1'b1;
                    w_state_nxt = S_RELEASE;
                end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_d     <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_timer       <= '0;
            r_respI_valid <= 1'b0;
            r_respD_valid <= 1'b0;
            r_ackD        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_respI_data  <= '0;
            r_respD_data  <= '0;
        end else begin
            r_respI_valid <= w_cap_rd & ~r_owner_d;
            r_respD_valid <= w_cap_rd & r_owner_d;
            r_ackD        <= w_cap_wr;
            r_timeout_err <= w_abort;
            if (w_grant) begin
                r_owner_d <= w_pick_d;
                r_we      <= w_pick_d & weD;
                r_addr    <= w_pick_d ? addrD : addrI;
                r_wdata   <= w_pick_d ? wdataD : '0;
                r_timer   <= '0;
            end else if (r_state == S_BUSY) begin
                r_timer   <= r_timer + 1'b1;
            end
            if (w_cap_rd && !r_owner_d) begin
                r_respI_data <= mem_rdata;
            end
            if (w_cap_rd && r_owner_d) begin
                r_respD_data <= mem_rdata;
            end
        end
    end

    assign mem_req     = (r_state == S_BUSY);
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign respI_valid = r_respI_valid;
    assign respI_data  = r_respI_data;
    assign respD_valid = r_respD_valid;
    assign respD_data  = r_respD_data;
    assign ackD        = r_ackD;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: write-back, refill, tie arbitration, stale request,
// watchdog abort and reset mid-transaction. Honours MEM_ARB_RR_EN for tie expectations.
module tb_mem_port_arbiter;
    localparam int AW = 28;
    localparam int W  = 128;
    localparam int TO = 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [W-1:0]  DATA_A5 = {16{8'hA5}};
    localparam logic [W-1:0]  DATA_DB = {4{32'hDEADBEEF}};
    localparam logic [W-1:0]  DATA_R1 = {4{32'h1111_0001}};
    localparam logic [W-1:0]  DATA_R2 = {4{32'h2222_0002}};
    localparam logic [AW-1:0] ADDR_I0 = 28'h0000010;
    localparam logic [AW-1:0] ADDR_D0 = 28'h1234567;
    localparam logic [AW-1:0] ADDR_I1 = 28'h0AAA000;
    localparam logic [AW-1:0] ADDR_D1 = 28'h0555000;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqI, reqD, weD;
    logic [AW-1:0] addrI, addrD;
    logic [W-1:0]  wdataD, mem_rdata;
    logic          mem_ready, mem_ack;
    logic          respI_valid, respD_valid, ackD, mem_req, mem_we, timeout_err;
    logic [W-1:0]  respI_data, respD_data, mem_wdata;
    logic [AW-1:0] mem_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt;
    int tcnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LINE_AW(AW), .LINE_W(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .reqI(reqI), .addrI(addrI), .respI_valid(respI_valid), .respI_data(respI_data),
        .reqD(reqD), .weD(weD), .addrD(addrD), .wdataD(wdataD),
        .respD_valid(respD_valid), .respD_data(respD_data), .ackD(ackD),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_ack(mem_ack),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_req"},     W'(mem_req), '0);
        chk({tag, " mem_we"},      W'(mem_we), '0);
        chk({tag, " mem_addr"},    W'(mem_addr), '0);
        chk({tag, " mem_wdata"},   mem_wdata, '0);
        chk({tag, " respI_valid"}, W'(respI_valid), '0);
        chk({tag, " respD_valid"}, W'(respD_valid), '0);
        chk({tag, " respI_data"},  respI_data, '0);
        chk({tag, " respD_data"},  respD_data, '0);
        chk({tag, " ackD"},        W'(ackD), '0);
        chk({tag, " timeout_err"}, W'(timeout_err), '0);
    endtask

    initial begin
        reset = 1'b1; reqI = 1'b0; reqD = 1'b0; weD = 1'b0;
        addrI = '0; addrD = '0; wdataD = '0; mem_rdata = '0;
        mem_ready = 1'b0; mem_ack = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // D write-back; a stray mem_ready must not complete it
        reqD = 1'b1; weD = 1'b1; addrD = ADDR_D0; wdataD = DATA_DB;
        tick();
        chk("wb mem_req", W'(mem_req), W'(1'b1));
        chk("wb mem_we", W'(mem_we), W'(1'b1));
        chk("wb mem_addr", W'(mem_addr), W'(ADDR_D0));
        chk("wb mem_wdata", mem_wdata, DATA_DB);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("wb ready ignored", W'(mem_req), W'(1'b1));
        chk("wb no early ack", W'(ackD), '0);
        addrD = ADDR_D1; wdataD = '0;
        chk("wb addr stable", W'(mem_addr), W'(ADDR_D0));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("wb ackD pulse", W'(ackD), W'(1'b1));
        chk("wb respD_valid", W'(respD_valid), '0);
        chk("wb mem_req drop", W'(mem_req), '0);
        reqD = 1'b0; weD = 1'b0;
        tick();
        chk("wb ackD one cycle", W'(ackD), '0);
        tick();
        chk("wb no regrant", W'(mem_req), '0);

        // I refill, response 3 cycles after mem_req; mem_ack during a read is ignored
        reqI = 1'b1; addrI = ADDR_I0;
        tick();
        chk("i mem_req", W'(mem_req), W'(1'b1));
        chk("i mem_addr", W'(mem_addr), W'(ADDR_I0));
        chk("i mem_we", W'(mem_we), '0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("i ack ignored", W'(mem_req), W'(1'b1));
        tick();
        chk("i still busy", W'(mem_req), W'(1'b1));
        chk("i no early resp", W'(respI_valid), '0);
        tick();
        mem_ready = 1'b1; mem_rdata = DATA_A5;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        chk("i respI_valid", W'(respI_valid), W'(1'b1));
        chk("i respI_data", respI_data, DATA_A5);
        chk("i respD_valid", W'(respD_valid), '0);
        chk("i mem_req drop", W'(mem_req), '0);
        reqI = 1'b0;
        tick();
        chk("i valid one cycle", W'(respI_valid), '0);
        chk("i data held", respI_data, DATA_A5);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req) cnt++;
            tick();
        end
        chk("stale no regrant", W'(cnt), '0);

        // Tie held across two transactions; last grant was I
        reqI = 1'b1; addrI = ADDR_I1;
        reqD = 1'b1; weD = 1'b0; addrD = ADDR_D1;
        tick();
        chk("tie1 mem_addr", W'(mem_addr), W'(ADDR_D1));
        mem_ready = 1'b1; mem_rdata = DATA_R1;
        tick();
        mem_ready = 1'b0;
        chk("tie1 respD_valid", W'(respD_valid), W'(1'b1));
        chk("tie1 respD_data", respD_data, DATA_R1);
        chk("tie1 release", W'(mem_req), '0);
        tick();
        chk("tie idle gap", W'(mem_req), '0);
        tick();
        chk("tie2 mem_req", W'(mem_req), W'(1'b1));
        chk("tie2 mem_addr", W'(mem_addr), W'(RR ? ADDR_I1 : ADDR_D1));
        mem_ready = 1'b1; mem_rdata = DATA_R2;
        tick();
        mem_ready = 1'b0;
        chk("tie2 respI_valid", W'(respI_valid), W'(RR));
        chk("tie2 respD_valid", W'(respD_valid), W'(!RR));
        chk("tie2 resp data", RR ? respI_data : respD_data, DATA_R2);
        reqI = 1'b0; reqD = 1'b0;
        tick();
        tick();
        chk("tie done", W'(mem_req), '0);

        // Watchdog: silent memory
        reqI = 1'b1; addrI = ADDR_I0;
        tick();
        cnt = 0; tcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            cnt++;
            if (timeout_err) tcnt++;
            tick();
        end
        chk("to busy cycles", W'(cnt), W'(TO));
        chk("to err while busy", W'(tcnt), '0);
        chk("to err pulse", W'(timeout_err), W'(1'b1));
        chk("to no respI", W'(respI_valid), '0);
        reqI = 1'b0;
        tick();
        chk("to err one cycle", W'(timeout_err), '0);
        tick();
        chk("to back idle", W'(mem_req), '0);

        // Reset mid-BUSY with a late response
        reqD = 1'b1; weD = 1'b0; addrD = ADDR_D0;
        tick();
        chk("rst busy", W'(mem_req), W'(1'b1));
        reset = 1'b1; reqD = 1'b0;
        tick();
        reset = 1'b0;
        mem_ready = 1'b1; mem_rdata = DATA_A5;
        chk_all_zero("rst");
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        chk("rst late respD", W'(respD_valid), '0);
        chk("rst late respI", W'(respI_valid), '0);
        chk("rst late data", respD_data, '0);
        chk("rst idle", W'(mem_req), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
